// File: rtl/pong_pkg.sv
// pong_pkg: shared state, sound-event and winner codes for the pong engine
package pong_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SERVE, ST_RUN, ST_GOAL, ST_OVER} state_t;
    localparam logic [1:0] SND_NONE   = 2'b00;
    localparam logic [1:0] SND_WALL   = 2'b01;
    localparam logic [1:0] SND_PADDLE = 2'b10;
    localparam logic [1:0] SND_GOAL   = 2'b11;
    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_P1     = 2'b01;
    localparam logic [1:0] WIN_P2     = 2'b10;
    localparam int SPD_W = 4;
endpackage

// File: rtl/pong_ball_step.sv
// pong_ball_step: one frame of ball motion with wall, paddle and goal resolution
module pong_ball_step
    import pong_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BALL_SIZE = 8,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 64,
    parameter int PAD1_X    = 32,
    parameter int PAD2_X    = 600,
    parameter int SPEED_MAX = 6
) (
    input  logic [9:0]       i_x,
    input  logic [9:0]       i_y,
    input  logic             i_vx_neg,
    input  logic             i_vy_up,
    input  logic [SPD_W-1:0] i_speed,
    input  logic [9:0]       i_pos1,
    input  logic [9:0]       i_pos2,
    output logic [9:0]       o_x,
    output logic [9:0]       o_y,
    output logic             o_vx_neg,
    output logic             o_vy_up,
    output logic [SPD_W-1:0] o_speed,
    output logic             o_wall,
    output logic             o_pad,
    output logic             o_goal1,
    output logic             o_goal2
);
    localparam logic signed [10:0] L_BOT   = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] L_P1E   = 11'(PAD1_X + PAD_W);
    localparam logic signed [10:0] L_P2E   = 11'(PAD2_X - BALL_SIZE);
    localparam logic signed [10:0] L_RIGHT = 11'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] L_BS    = 12'(BALL_SIZE);
    localparam logic signed [11:0] L_PH    = 12'(PAD_H);
    localparam logic [SPD_W-1:0]   L_SMAX  = SPD_W'(SPEED_MAX);

    logic signed [10:0] w_x, w_y, w_spd, w_nx_raw, w_ny_raw, w_ny, w_nx;
    logic signed [11:0] w_ny12, w_p1, w_p2;
    logic               w_top, w_bot, w_y1, w_y2, w_hit1, w_hit2, w_hit;

    assign w_x      = $signed({1'b0, i_x});
    assign w_y      = $signed({1'b0, i_y});
    assign w_spd    = $signed({{(11 - SPD_W){1'b0}}, i_speed});
    assign w_nx_raw = i_vx_neg ? w_x - w_spd : w_x + w_spd;
    assign w_ny_raw = i_vy_up ? w_y - w_spd : w_y + w_spd;
    assign w_top    = w_ny_raw <= 11'sd0;
    assign w_bot    = w_ny_raw >= L_BOT;
    assign w_ny     = w_top ? 11'sd0 : w_bot ? L_BOT : w_ny_raw;
    // vertical overlap is tested with the wall-clamped y, in 12 bits so pos+PAD_H cannot wrap
    assign w_ny12   = {w_ny[10], w_ny};
    assign w_p1     = $signed({2'b00, i_pos1});
    assign w_p2     = $signed({2'b00, i_pos2});
    assign w_y1     = (w_ny12 + L_BS > w_p1) && (w_ny12 < w_p1 + L_PH);
    assign w_y2     = (w_ny12 + L_BS > w_p2) && (w_ny12 < w_p2 + L_PH);
    assign w_hit1   = i_vx_neg && (w_x >= L_P1E) && (w_nx_raw < L_P1E) && w_y1;
    assign w_hit2   = !i_vx_neg && (w_x <= L_P2E) && (w_nx_raw > L_P2E) && w_y2;
    assign w_hit    = w_hit1 || w_hit2;
    assign w_nx     = w_hit1 ? L_P1E : w_hit2 ? L_P2E : w_nx_raw;
    assign o_goal2  = w_nx < 11'sd0;
    assign o_goal1  = w_nx > L_RIGHT;
    assign o_x      = o_goal2 ? 10'd0 : o_goal1 ? L_RIGHT[9:0] : w_nx[9:0];
    assign o_y      = w_ny[9:0];
    assign o_vx_neg = w_hit ? ~i_vx_neg : i_vx_neg;
    assign o_vy_up  = (w_top || w_bot) ? ~i_vy_up : i_vy_up;
    assign o_speed  = !w_hit ? i_speed : (i_speed >= L_SMAX) ? L_SMAX : i_speed + 1'b1;
    assign o_wall   = w_top || w_bot;
    assign o_pad    = w_hit;
endmodule

// File: rtl/pong_engine.sv
// pong_engine: per-frame pong game FSM with serve timing, scoring and sound events
module pong_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 64,
    parameter int PAD1_X       = 32,
    parameter int PAD2_X       = 600,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 6,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       play,
    input  logic [9:0] pos_ply1,
    input  logic [9:0] pos_ply2,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       goal_ply1,
    output logic       goal_ply2,
    output logic [1:0] winner,
    output logic [1:0] snd_event,
    output logic       snd_valid
);
    localparam int                CW     = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0]     L_LOAD = CW'(SERVE_FRAMES - 1);
    localparam logic [9:0]        L_CX   = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]        L_CY   = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [SPD_W-1:0]  L_SI   = SPD_W'(SPEED_INIT);
    localparam logic [3:0]        L_WIN  = 4'(WIN_SCORE);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [9:0]       r_x, r_y;
    logic             r_vx_neg, r_vy_up, r_serve_neg;
    logic [SPD_W-1:0] r_speed;
    logic [3:0]       r_score1, r_score2;
    logic [1:0]       r_winner, r_snd_event;
    logic             r_goal1, r_goal2, r_snd_valid;

    logic [9:0]       w_nx, w_ny;
    logic             w_vx_neg, w_vy_up, w_wall, w_pad, w_goal1, w_goal2;
    logic [SPD_W-1:0] w_speed;

    pong_ball_step #(
        .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL_SIZE), .PAD_W(PAD_W),
        .PAD_H(PAD_H), .PAD1_X(PAD1_X), .PAD2_X(PAD2_X), .SPEED_MAX(SPEED_MAX)
    ) u_step (
        .i_x(r_x), .i_y(r_y), .i_vx_neg(r_vx_neg), .i_vy_up(r_vy_up),
        .i_speed(r_speed), .i_pos1(pos_ply1), .i_pos2(pos_ply2),
        .o_x(w_nx), .o_y(w_ny), .o_vx_neg(w_vx_neg), .o_vy_up(w_vy_up),
        .o_speed(w_speed), .o_wall(w_wall), .o_pad(w_pad),
        .o_goal1(w_goal1), .o_goal2(w_goal2)
    );

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_x         <= L_CX;
            r_y         <= L_CY;
            r_vx_neg    <= 1'b0;
            r_vy_up     <= 1'b0;
            r_serve_neg <= 1'b0;
            r_speed     <= L_SI;
            r_score1    <= '0;
            r_score2    <= '0;
            r_winner    <= WIN_NONE;
            r_goal1     <= 1'b0;
            r_goal2     <= 1'b0;
            r_snd_event <= SND_NONE;
            r_snd_valid <= 1'b0;
        end else begin
            r_goal1     <= 1'b0;
            r_goal2     <= 1'b0;
            r_snd_event <= SND_NONE;
            r_snd_valid <= 1'b0;
            if (frame_tick) begin
                case (r_state)
                    ST_IDLE: if (play) begin
                        r_state <= ST_SERVE;
                        r_cnt   <= L_LOAD;
                    end
                    ST_SERVE: if (r_cnt == '0) begin
                        r_state  <= ST_RUN;
                        r_speed  <= L_SI;
                        r_vy_up  <= 1'b0;
                        r_vx_neg <= r_serve_neg;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    ST_RUN: begin
                        r_x         <= w_nx;
                        r_y         <= w_ny;
                        r_vx_neg    <= w_vx_neg;
                        r_vy_up     <= w_vy_up;
                        r_speed     <= w_speed;
                        r_goal1     <= w_goal1;
                        r_goal2     <= w_goal2;
                        r_snd_valid <= w_goal1 || w_goal2 || w_pad || w_wall;
                        r_snd_event <= (w_goal1 || w_goal2) ? SND_GOAL :
                                       w_pad ? SND_PADDLE : w_wall ? SND_WALL : SND_NONE;
                        // next serve heads toward whoever just conceded
                        if (w_goal1) begin
                            r_score1    <= r_score1 + 4'd1;
                            r_serve_neg <= 1'b0;
                            r_state     <= ST_GOAL;
                        end
                        if (w_goal2) begin
                            r_score2    <= r_score2 + 4'd1;
                            r_serve_neg <= 1'b1;
                            r_state     <= ST_GOAL;
                        end
                    end
                    ST_GOAL: begin
                        r_x <= L_CX;
                        r_y <= L_CY;
                        if (r_score1 == L_WIN || r_score2 == L_WIN) begin
                            r_state  <= ST_OVER;
                            r_winner <= (r_score1 == L_WIN) ? WIN_P1 : WIN_P2;
                        end else begin
                            r_state <= ST_SERVE;
                            r_cnt   <= L_LOAD;
                        end
                    end
                    ST_OVER: if (play) begin
                        r_score1 <= '0;
                        r_score2 <= '0;
                        r_winner <= WIN_NONE;
                        r_state  <= ST_SERVE;
                        r_cnt    <= L_LOAD;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign x_ball    = r_x;
    assign y_ball    = r_y;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign winner    = r_winner;
    assign goal_ply1 = r_goal1;
    assign goal_ply2 = r_goal2;
    assign snd_event = r_snd_event;
    assign snd_valid = r_snd_valid;
endmodule
